// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter feeding the 8-to-3 one-hot encoder.
// The grant is registered and strictly one-hot. It is held until the owner
// pulses done or drops its request. Priority then rotates to the index just
// past the last owner, and one all-zero grant cycle separates owners.
// Optional hold-time limit: define RR_GRANT_TIMEOUT_EN to build a counter
// that force-releases a grant held for TIMEOUT cycles. Without the macro the
// timeout output is tied low and a grant can be held indefinitely.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no owner, grant=0; arbitrate among req starting at ptr
// GRANT   | one owner holds grant until done, req drop or timeout

module rr_grant_arbiter #(
   parameter int N       = 8,
   parameter int TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         done,
   output logic [N-1:0] grant,
   output logic         grant_valid,
   output logic         timeout
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   if (N < 2 || N > 8 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_param
      $error("rr_grant_arbiter: N must be 2..8 and TIMEOUT 2..65535");
   end

   logic [0:0]    state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [N-1:0]  grant_q, grant_d;

   logic [N-1:0]  req_rot;
   logic [PW-1:0] pick_off;
   logic          pick_found;
   logic [PW:0]   pick_sum;
   logic [N-1:0]  pick_onehot;
   logic [PW-1:0] owner_idx;
   logic [PW-1:0] ptr_after_owner;
   logic          rel_normal;

`ifdef RR_GRANT_TIMEOUT_EN
   localparam logic [15:0] HOLD_LAST = 16'(TIMEOUT - 1);
   logic [15:0] hold_cnt_q, hold_cnt_d;
   logic        timeout_q, timeout_d;
`endif

   // Rotate requests so that ptr lands at bit 0, then take the first set bit.
   always_comb begin
      req_rot    = N'({req, req} >> ptr_q);
      pick_off   = '0;
      pick_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!pick_found && req_rot[i]) begin
            pick_off   = PW'(i);
            pick_found = 1'b1;
         end
      end
      pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
      if (pick_sum >= (PW+1)'(N)) begin
         pick_sum = pick_sum - (PW+1)'(N);
      end
      pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick_sum[PW-1:0];
   end

   // Encode the current owner and the pointer value that follows it.
   always_comb begin
      owner_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_q[i]) begin
            owner_idx = PW'(i);
         end
      end
      if (owner_idx == PW'(N - 1)) begin
         ptr_after_owner = '0;
      end else begin
         ptr_after_owner = owner_idx + PW'(1);
      end
      rel_normal = done || ((req & grant_q) == '0);
   end

   // Next-state logic for the arbitration FSM.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
`ifdef RR_GRANT_TIMEOUT_EN
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req != '0) begin
               grant_d = pick_onehot;
               state_d = ST_GRANT;
`ifdef RR_GRANT_TIMEOUT_EN
               hold_cnt_d = '0;
`endif
            end
         end
         ST_GRANT: begin
            if (rel_normal) begin
               grant_d = '0;
               ptr_d   = ptr_after_owner;
               state_d = ST_IDLE;
            end
`ifdef RR_GRANT_TIMEOUT_EN
            else if (hold_cnt_q == HOLD_LAST) begin
               grant_d   = '0;
               ptr_d     = ptr_after_owner;
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + 16'd1;
            end
`endif
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
`ifdef RR_GRANT_TIMEOUT_EN
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
`ifdef RR_GRANT_TIMEOUT_EN
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
`ifdef RR_GRANT_TIMEOUT_EN
   assign timeout     = timeout_q;
`else
   assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter (N=8). Each scenario builds a table of
// per-cycle stimulus with the grant/timeout expected after the next edge;
// expectations go into a scoreboard queue as stimulus is driven and are
// popped and compared once the edge has passed. A monitor checks the
// one-hot / valid / request-subset invariants on every falling edge.
// Build with RR_GRANT_TIMEOUT_EN defined to run with TIMEOUT=4.

module tb_rr_grant_arbiter;

   localparam int N = 8;
`ifdef RR_GRANT_TIMEOUT_EN
   localparam int TO_CYC = 4;
`else
   localparam int TO_CYC = 255;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic       grant_valid;
   logic       timeout;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       rst_n;
      logic [7:0] req;
      logic       done;
      logic [7:0] grant;
      logic       to;
   } vec_t;

   typedef struct {
      logic [7:0] grant;
      logic       to;
   } exp_t;

   exp_t sb[$];

   rr_grant_arbiter #(.N(N), .TIMEOUT(TO_CYC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog expired");
   end

   // Invariants, sampled away from the rising edge.
   logic [7:0] prev_req   = 8'h00;
   logic [7:0] prev_grant = 8'h00;
   always @(negedge clk) begin
      n_checks++;
      if ($isunknown(grant) || ((grant & (grant - 8'd1)) != 8'h00)) begin
         n_fail++;
         $display("FAIL inv_onehot: grant=%h, required zero or one-hot", grant);
      end
      n_checks++;
      if (grant_valid !== (grant != 8'h00)) begin
         n_fail++;
         $display("FAIL inv_valid: grant_valid=%b, required %b", grant_valid, grant != 8'h00);
      end
      if (prev_grant == 8'h00 && grant != 8'h00) begin
         n_checks++;
         if ((grant & ~prev_req) != 8'h00) begin
            n_fail++;
            $display("FAIL inv_req: grant=%h with req=%h at arbitration, required grant within req", grant, prev_req);
         end
      end
      prev_req   = req;
      prev_grant = grant;
   end

   task automatic test_reset();
      vec_t v[$];
      exp_t e;
      for (int k = 0; k < 3; k++) v.push_back('{1'b0, 8'hFF, 1'b0, 8'h00, 1'b0});
      v.push_back('{1'b1, 8'hFF, 1'b0, 8'h01, 1'b0});
      foreach (v[i]) begin
         rst_n = v[i].rst_n; req = v[i].req; done = v[i].done;
         sb.push_back('{v[i].grant, v[i].to});
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if (grant !== e.grant || grant_valid !== (e.grant != 8'h00) || timeout !== e.to) begin
            n_fail++;
            $display("FAIL reset step %0d: grant=%h valid=%b timeout=%b, required grant=%h valid=%b timeout=%b",
                     i, grant, grant_valid, timeout, e.grant, e.grant != 8'h00, e.to);
         end
      end
   endtask

   task automatic test_rotation();
      vec_t v[$];
      exp_t e;
      for (int k = 1; k <= 8; k++) begin
         v.push_back('{1'b1, 8'hFF, 1'b1, 8'h00, 1'b0});
         v.push_back('{1'b1, 8'hFF, 1'b0, 8'(1 << (k % 8)), 1'b0});
      end
      foreach (v[i]) begin
         rst_n = v[i].rst_n; req = v[i].req; done = v[i].done;
         sb.push_back('{v[i].grant, v[i].to});
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if (grant !== e.grant || grant_valid !== (e.grant != 8'h00) || timeout !== e.to) begin
            n_fail++;
            $display("FAIL rotation step %0d: grant=%h valid=%b timeout=%b, required grant=%h valid=%b timeout=%b",
                     i, grant, grant_valid, timeout, e.grant, e.grant != 8'h00, e.to);
         end
      end
   endtask

   // Owner 0 held on entry; ptr=0.
   task automatic test_wrap();
      vec_t v[$];
      exp_t e;
      v.push_back('{1'b1, 8'h00, 1'b1, 8'h00, 1'b0});
      v.push_back('{1'b1, 8'h20, 1'b0, 8'h20, 1'b0});
      v.push_back('{1'b1, 8'h20, 1'b1, 8'h00, 1'b0});
      v.push_back('{1'b1, 8'h21, 1'b0, 8'h01, 1'b0});
      v.push_back('{1'b1, 8'h21, 1'b1, 8'h00, 1'b0});
      v.push_back('{1'b1, 8'h21, 1'b0, 8'h20, 1'b0});
      v.push_back('{1'b1, 8'h21, 1'b1, 8'h00, 1'b0});
      v.push_back('{1'b1, 8'h01, 1'b0, 8'h01, 1'b0});
      v.push_back('{1'b1, 8'h00, 1'b0, 8'h00, 1'b0});
      foreach (v[i]) begin
         rst_n = v[i].rst_n; req = v[i].req; done = v[i].done;
         sb.push_back('{v[i].grant, v[i].to});
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if (grant !== e.grant || grant_valid !== (e.grant != 8'h00) || timeout !== e.to) begin
            n_fail++;
            $display("FAIL wrap step %0d: grant=%h valid=%b timeout=%b, required grant=%h valid=%b timeout=%b",
                     i, grant, grant_valid, timeout, e.grant, e.grant != 8'h00, e.to);
         end
      end
   endtask

   // Idle with ptr=1 on entry.
   task automatic test_req_drop();
      vec_t v[$];
      exp_t e;
      v.push_back('{1'b1, 8'h00, 1'b1, 8'h00, 1'b0});
      v.push_back('{1'b1, 8'h08, 1'b0, 8'h08, 1'b0});
      v.push_back('{1'b1, 8'h0F, 1'b0, 8'h08, 1'b0});
      v.push_back('{1'b1, 8'h02, 1'b0, 8'h00, 1'b0});
      v.push_back('{1'b1, 8'h02, 1'b0, 8'h02, 1'b0});
      v.push_back('{1'b1, 8'h02, 1'b1, 8'h00, 1'b0});
      foreach (v[i]) begin
         rst_n = v[i].rst_n; req = v[i].req; done = v[i].done;
         sb.push_back('{v[i].grant, v[i].to});
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if (grant !== e.grant || grant_valid !== (e.grant != 8'h00) || timeout !== e.to) begin
            n_fail++;
            $display("FAIL req_drop step %0d: grant=%h valid=%b timeout=%b, required grant=%h valid=%b timeout=%b",
                     i, grant, grant_valid, timeout, e.grant, e.grant != 8'h00, e.to);
         end
      end
   endtask

   // Idle with ptr=2 on entry; after reset ptr must be 0 again.
   task automatic test_reset_mid_grant();
      vec_t v[$];
      exp_t e;
      v.push_back('{1'b1, 8'h10, 1'b0, 8'h10, 1'b0});
      v.push_back('{1'b0, 8'h10, 1'b0, 8'h00, 1'b0});
      v.push_back('{1'b1, 8'h11, 1'b0, 8'h01, 1'b0});
      v.push_back('{1'b1, 8'h00, 1'b0, 8'h00, 1'b0});
      foreach (v[i]) begin
         rst_n = v[i].rst_n; req = v[i].req; done = v[i].done;
         sb.push_back('{v[i].grant, v[i].to});
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if (grant !== e.grant || grant_valid !== (e.grant != 8'h00) || timeout !== e.to) begin
            n_fail++;
            $display("FAIL reset_mid step %0d: grant=%h valid=%b timeout=%b, required grant=%h valid=%b timeout=%b",
                     i, grant, grant_valid, timeout, e.grant, e.grant != 8'h00, e.to);
         end
      end
   endtask

   task automatic test_hold();
      vec_t v[$];
      exp_t e;
      v.push_back('{1'b1, 8'h04, 1'b0, 8'h04, 1'b0});
`ifdef RR_GRANT_TIMEOUT_EN
      for (int k = 1; k < TO_CYC; k++) v.push_back('{1'b1, 8'h04, 1'b0, 8'h04, 1'b0});
      v.push_back('{1'b1, 8'h04, 1'b0, 8'h00, 1'b1});
      v.push_back('{1'b1, 8'h04, 1'b0, 8'h04, 1'b0});
      for (int k = 1; k < TO_CYC; k++) v.push_back('{1'b1, 8'h04, 1'b0, 8'h04, 1'b0});
      v.push_back('{1'b1, 8'h04, 1'b1, 8'h00, 1'b0});
`else
      for (int k = 1; k < 100; k++) v.push_back('{1'b1, 8'h04, 1'b0, 8'h04, 1'b0});
      v.push_back('{1'b1, 8'h04, 1'b1, 8'h00, 1'b0});
`endif
      v.push_back('{1'b1, 8'h00, 1'b0, 8'h00, 1'b0});
      foreach (v[i]) begin
         rst_n = v[i].rst_n; req = v[i].req; done = v[i].done;
         sb.push_back('{v[i].grant, v[i].to});
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if (grant !== e.grant || grant_valid !== (e.grant != 8'h00) || timeout !== e.to) begin
            n_fail++;
            $display("FAIL hold step %0d: grant=%h valid=%b timeout=%b, required grant=%h valid=%b timeout=%b",
                     i, grant, grant_valid, timeout, e.grant, e.grant != 8'h00, e.to);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 8'hFF;
      done  = 1'b0;
      test_reset();
      test_rotation();
      test_wrap();
      test_req_drop();
      test_reset_mid_grant();
      test_hold();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
